btn_debounce: RTL and testbench
===============================

# btn_debounce

Input-side counterpart to the LED driver: synchronises, debounces and edge-detects the seven ULX3S push-buttons in the `i_clk` domain. Presents clean per-button levels plus single-cycle press and release pulses to downstream logic such as LED, counter or mode-select state. Sits directly between the `btn` pins and any user logic; no other block reads raw `btn`.

## Interface

- `NBTN`, 7: number of buttons handled.
- `DEBOUNCE_CYCLES`, 250000: cycles an input must remain stable before it is accepted. 250000 is 10 ms at 25 MHz. Legal range ≥ 1.
- `CTR_WIDTH`, 18: debounce counter width. Must satisfy 2^CTR_WIDTH ≥ DEBOUNCE_CYCLES.
- `INVERT_MASK`, 7'b0000001: per-bit inversion applied before the synchroniser. btn[0] (PWR) is active-low on the board.
- `i_clk`, in, 1: the single clock, 25 MHz on hardware.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_btn`, in, NBTN: raw asynchronous button pins.
- `o_level`, out, NBTN: debounced level, 1 = pressed (after inversion).
- `o_press`, out, NBTN: one-cycle pulse when `o_level[n]` goes 0→1.
- `o_release`, out, NBTN: one-cycle pulse when `o_level[n]` goes 1→0.

## Operation

- Per bit, input path is: `i_btn ^ INVERT_MASK` → 2-flop synchroniser (`sync1`, `sync2`) → debounce FSM.
- Per-bit debounce state is `state`, the accepted level, and counter `cnt`. Evaluated on every `i_clk` edge:
  - `sync2 == state`: `cnt <= 0`. No change.
  - `sync2 != state` and `cnt != DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `sync2 != state` and `cnt == DEBOUNCE_CYCLES-1`: `state <= sync2`, `cnt <= 0`. Assert `o_press[n]` if `sync2` = 1, otherwise `o_release[n]`, for exactly the next cycle.
- `o_level = state`. Pulses are registered alongside `state` and are never combinational.
- A glitch shorter than DEBOUNCE_CYCLES consecutive differing samples resets `cnt` and produces no output change.
- Bits are fully independent. Simultaneous presses on several buttons yield simultaneous pulses.
- `o_press` and `o_release` for the same bit are never high together. Consecutive pulses on one bit are separated by at least DEBOUNCE_CYCLES cycles.
- Reset, held any length and applied at any time including mid-count: `sync1`, `sync2`, `state`, `cnt` go to 0, and `o_level`, `o_press`, `o_release` read 0 the cycle after. No pulse is emitted on reset entry or exit.
- A button held through reset appears as a normal press after reset is released.

## Timing

- Edge 0 is the first edge at which `sync1` samples a new stable value.
- `sync2` holds the new value after edge 1. Counting occurs on edges 2 … DEBOUNCE_CYCLES+1.
- `o_level` and the matching pulse change after edge DEBOUNCE_CYCLES+1. Total latency is DEBOUNCE_CYCLES+2 cycles.
- With DEBOUNCE_CYCLES = 1, the output changes after edge 2.
- Reset release: the first edge with `i_reset` low is edge 0 for a held button. Latency is identical to the above.
- Each pulse is exactly one cycle wide, and only when a change is accepted.

## Structure

- Shared include `btn_pkg.vh` holds `NBTN`, the board `INVERT_MASK`, and the default `DEBOUNCE_CYCLES` for 25 MHz.
- Sub-module `debounce_bit` contains the synchroniser, counter, state and pulse flops for one button. `btn_debounce` instantiates `NBTN` copies via generate and applies the inversion mask.
- The Verilator build uses a small DEBOUNCE_CYCLES (4) through a parameter override. No behavioural `ifdef` is allowed in the RTL.

## Test plan

All scenarios run with DEBOUNCE_CYCLES = 4 and INVERT_MASK = 0 unless noted.

1. Reset held 3 cycles with `i_btn` = 7'h7F, then released:
   - all outputs stay 0 through reset.
   - `o_level` = 7'h7F after 6 cycles.
   - `o_press` = 7'h7F for exactly 1 cycle, then 0.
2. btn[1] stepped 0→1 and held:
   - `o_level[1]` rises exactly 6 cycles after the step edge.
   - `o_press[1]` is high for 1 cycle.
   - `o_release` stays 0.
3. btn[2] toggled with a 3-cycle high glitch, repeated 10 times:
   - `o_level[2]` stays 0.
   - no pulses.
4. btn[3] pressed, then released after 20 cycles:
   - one `o_press[3]`, then `o_release[3]` 20 cycles after the press pulse.
   - never both high together.
5. Reset asserted while btn[4]'s `cnt` = 2:
   - `cnt` clears and no pulse occurs.
   - after release, the press is accepted with full 6-cycle latency.
6. INVERT_MASK = 7'b0000001, btn[0] held low from reset:
   - `o_level[0]` = 1 and `o_press[0]` pulses once.
   - raising btn[0] yields `o_release[0]` 6 cycles later.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared constants and types for the push-button debouncer.
//   BTN_COUNT            : number of board buttons
//   BTN_INVERT_MASK      : board polarity mask (btn[0] PWR is active-low)
//   BTN_DEBOUNCE_CYCLES  : 10 ms at 25 MHz
//   BTN_CTR_WIDTH        : counter width able to hold BTN_DEBOUNCE_CYCLES-1
//   dbnc_out_t           : per-button debounced outputs
package btn_debounce_pkg;

  localparam int                   BTN_COUNT           = 7;
  localparam logic [BTN_COUNT-1:0] BTN_INVERT_MASK     = 7'b0000001;
  localparam int                   BTN_DEBOUNCE_CYCLES = 250000;
  localparam int                   BTN_CTR_WIDTH       = 18;

  typedef struct packed {
    logic level;  // accepted level, 1 = pressed
    logic press;  // one-cycle pulse on 0->1
    logic rel;    // one-cycle pulse on 1->0
  } dbnc_out_t;

endpackage

// File: rtl/btn_debounce_bit.sv
// One-button debouncer: 2-flop synchroniser, stability counter, accepted
// state and registered press/release pulses.
//   clk   : clock
//   reset : synchronous, active-high
//   din   : raw (already polarity-corrected) asynchronous input
//   dout  : accepted level plus press/release pulses
module debounce_bit
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int CTR_WIDTH       = BTN_CTR_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      din,
  output dbnc_out_t dout
);

  localparam logic [CTR_WIDTH-1:0] CNT_LAST = CTR_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1, sync2;
  logic                 state, state_nxt;
  logic [CTR_WIDTH-1:0] cnt, cnt_nxt;
  logic                 press, press_nxt;
  logic                 rel, rel_nxt;

  // State register (synchroniser included so reset clears the whole path).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  // Next state: any sample matching the accepted level restarts the count,
  // so only an unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    if (sync2 != state) begin
      if (cnt == CNT_LAST) begin
        state_nxt = sync2;
        press_nxt = sync2;
        rel_nxt   = ~sync2;
      end else begin
        cnt_nxt = cnt + CTR_WIDTH'(1);
      end
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    dout.level = state;
    dout.press = press;
    dout.rel   = rel;
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounces and edge-detects NBTN asynchronous push-buttons in the i_clk
// domain.
//   i_clk     : single clock (25 MHz on hardware)
//   i_reset   : synchronous, active-high reset
//   i_btn     : raw button pins
//   o_level   : debounced level, 1 = pressed (after INVERT_MASK)
//   o_press   : one-cycle pulse when o_level[n] goes 0->1
//   o_release : one-cycle pulse when o_level[n] goes 1->0
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int              NBTN            = BTN_COUNT,
  parameter int              DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int              CTR_WIDTH       = BTN_CTR_WIDTH,
  parameter logic [NBTN-1:0] INVERT_MASK     = NBTN'(BTN_INVERT_MASK)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NBTN-1:0] i_btn,
  output logic [NBTN-1:0] o_level,
  output logic [NBTN-1:0] o_press,
  output logic [NBTN-1:0] o_release
);

  // Inversion ahead of the synchroniser so every bit downstream is active-high.
  logic [NBTN-1:0] btn_pol;
  dbnc_out_t       bit_out [NBTN];

  assign btn_pol = i_btn ^ INVERT_MASK;

  for (genvar g = 0; g < NBTN; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CTR_WIDTH       (CTR_WIDTH)
    ) u_bit (
      .clk   (i_clk),
      .reset (i_reset),
      .din   (btn_pol[g]),
      .dout  (bit_out[g])
    );
    assign o_level[g]   = bit_out[g].level;
    assign o_press[g]   = bit_out[g].press;
    assign o_release[g] = bit_out[g].rel;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios followed by random
// stimulus, all compared against a sliding-window reference model.
module tb_btn_debounce;

  localparam int D    = 4;
  localparam int MAXE = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] btn, btn2;
  logic [6:0] lvl1, prs1, rel1;
  logic [6:0] lvl2, prs2, rel2;

  always #5 clk = ~clk;

  btn_debounce #(.NBTN(7), .DEBOUNCE_CYCLES(D), .CTR_WIDTH(3), .INVERT_MASK(7'h00)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_btn(btn),
    .o_level(lvl1), .o_press(prs1), .o_release(rel1));

  btn_debounce #(.NBTN(7), .DEBOUNCE_CYCLES(D), .CTR_WIDTH(3), .INVERT_MASK(7'h01)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_btn(btn2),
    .o_level(lvl2), .o_press(prs2), .o_release(rel2));

  int passed = 0;
  int total  = 0;

  // Reference model: per-edge history of the polarity-corrected inputs and
  // reset. A bit flips at edge e when the synchronised samples seen at the
  // last D edges all differ from the accepted level and none of those edges
  // was a reset edge.
  logic [6:0] hin  [2][MAXE];
  bit         hrst [MAXE];
  logic [6:0] mlvl [2] = '{7'h00, 7'h00};
  logic [6:0] mprs [2] = '{7'h00, 7'h00};
  logic [6:0] mrel [2] = '{7'h00, 7'h00};
  int         e = 0;

  function automatic bit rst_at(int x);
    if (x < 0) return 1'b1;
    return hrst[x];
  endfunction

  // Value the debouncer sees at edge x: the input from two edges earlier,
  // unless a reset in between flushed the synchroniser.
  function automatic logic sbit(int m, int x, int b);
    if (x < 2) return 1'b0;
    if (rst_at(x - 1) || rst_at(x - 2)) return 1'b0;
    return hin[m][x-2][b];
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      mprs[m] = '0;
      mrel[m] = '0;
      if (hrst[e]) begin
        mlvl[m] = '0;
      end else begin
        for (int b = 0; b < 7; b++) begin
          bit flip = 1'b1;
          for (int k = 0; k < D; k++) begin
            if (rst_at(e - k)) flip = 1'b0;
            else if (sbit(m, e - k, b) == mlvl[m][b]) flip = 1'b0;
          end
          if (flip) begin
            mlvl[m][b] = ~mlvl[m][b];
            if (mlvl[m][b]) mprs[m][b] = 1'b1;
            else            mrel[m][b] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, e);
  endtask

  task automatic chki(string tag, int obs, int exp);
    total++;
    assert (obs == exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: record what the DUTs sample, advance the model, then compare.
  task automatic tick();
    @(posedge clk);
    if (e >= MAXE) begin
      $display("FAIL history: model buffer exhausted at edge %0d", e);
      $fatal(1, "history overflow");
    end
    hin[0][e] = btn;
    hin[1][e] = btn2 ^ 7'h01;
    hrst[e]   = rst;
    model_edge();
    e++;
    #1;
    chk("level1",   lvl1, mlvl[0]);
    chk("press1",   prs1, mprs[0]);
    chk("release1", rel1, mrel[0]);
    chk("excl1",    prs1 & rel1, 7'h00);
    chk("level2",   lvl2, mlvl[1]);
    chk("press2",   prs2, mprs[1]);
    chk("release2", rel2, mrel[1]);
    chk("excl2",    prs2 & rel2, 7'h00);
  endtask

  initial begin
    int p, r;

    // 1: reset held 3 cycles with all buttons pressed, then released.
    rst  = 1'b1;
    btn  = 7'h7F;
    btn2 = 7'h00;   // dut2 btn[0] held low (pressed after inversion)
    repeat (3) begin
      tick();
      chk("s1_rst_level", lvl1, 7'h00);
      chk("s1_rst_press", prs1, 7'h00);
      chk("s6_rst_level", lvl2, 7'h00);
    end
    rst = 1'b0;
    repeat (5) tick();
    chk("s1_level_early", lvl1, 7'h00);
    tick();
    chk("s1_level", lvl1, 7'h7F);
    chk("s1_press", prs1, 7'h7F);
    chk("s6_level", lvl2, 7'h01);
    chk("s6_press", prs2, 7'h01);
    tick();
    chk("s1_press_end", prs1, 7'h00);
    chk("s6_press_end", prs2, 7'h00);

    // 2: release everything, then step btn[1].
    btn = 7'h00;
    repeat (8) tick();
    btn = 7'h02;
    repeat (5) tick();
    chk("s2_level_early", lvl1, 7'h00);
    tick();
    chk("s2_level",   lvl1, 7'h02);
    chk("s2_press",   prs1, 7'h02);
    chk("s2_release", rel1, 7'h00);
    tick();
    chk("s2_press_end", prs1, 7'h00);

    // 3: 3-cycle high glitches on btn[2] must be rejected.
    repeat (10) begin
      btn[2] = 1'b1;
      repeat (3) begin
        tick();
        chk("s3_level", lvl1, 7'h02);
        chk("s3_pulse", prs1 | rel1, 7'h00);
      end
      btn[2] = 1'b0;
      repeat (3) begin
        tick();
        chk("s3_level", lvl1, 7'h02);
        chk("s3_pulse", prs1 | rel1, 7'h00);
      end
    end

    // 4: btn[3] pressed for 20 cycles; release pulse 20 cycles after press pulse.
    p = -1;
    r = -1;
    btn[3] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (prs1[3] && p < 0) p = i;
    end
    btn[3] = 1'b0;
    for (int i = 21; i <= 60; i++) begin
      tick();
      if (rel1[3] && r < 0) r = i;
    end
    chki("s4_press_at", p, 6);
    chki("s4_release_gap", (r < 0) ? -1 : r - p, 20);

    // 5: reset while btn[4]'s count is at 2.
    btn[4] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) begin
      tick();
      chk("s5_rst_level", lvl1, 7'h00);
      chk("s5_rst_pulse", prs1 | rel1, 7'h00);
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("s5_no_pulse", prs1 | rel1, 7'h00);
    end
    tick();
    chk("s5_level", lvl1, 7'h12);
    chk("s5_press", prs1, 7'h12);

    // 6: raise the active-low btn[0] on the inverted instance.
    btn2[0] = 1'b1;
    repeat (5) begin
      tick();
      chk("s6_no_release", rel2, 7'h00);
    end
    tick();
    chk("s6_release",     rel2, 7'h01);
    chk("s6_level_after", lvl2, 7'h00);

    // Random phase: mix of glitches, stable runs and occasional resets.
    repeat (1000) begin
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 4) == 0) btn[b]  = ~btn[b];
        if ($urandom_range(0, 4) == 0) btn2[b] = ~btn2[b];
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
